bias_gradient_updater: RTL



---
 rtl/bias_gradient_updater.sv | 133 +++++++++++++
 1 files changed

// File: rtl/bias_gradient_updater.sv
// Bias update stage of the backward pass: accumulates a batch of dL/dZ gradients,
// scales the sum by the learning rate and subtracts the step from the bias (signed Q8.8).
module bias_gradient_updater #(
    parameter int BATCH_SIZE = 4,
    parameter int ACC_WIDTH  = 24,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 grad_valid_in,
    input  logic [15:0]          grad_data_in,
    input  logic [15:0]          lr_in,
    input  logic                 bias_load_in,
    input  logic [15:0]          bias_init_in,
    output logic                 grad_ready_out,
    output logic [15:0]          bias_out,
    output logic                 bias_update_valid_out,
    output logic [CNT_WIDTH-1:0] sample_count_out,
    output logic                 drop_sticky_out
);

    localparam int PW = ACC_WIDTH + 16;
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(BATCH_SIZE - 1);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_SCALE = 2'd1,
        ST_APPLY = 2'd2
    } state_t;

    state_t                 state, state_next;
    logic [ACC_WIDTH-1:0]   acc;
    logic [CNT_WIDTH-1:0]   count;
    logic [15:0]            step;

    logic [ACC_WIDTH:0]     acc_sum;
    logic [ACC_WIDTH-1:0]   acc_sat;
    logic signed [PW-1:0]   acc_ext, lr_ext, prod, prod_shr;
    logic [15:0]            step_sat;
    logic [16:0]            bias_diff;
    logic [15:0]            bias_sat;

    assign grad_ready_out   = (state == ST_ACCUM);
    assign sample_count_out = count;

    // Accumulate one bit wider so overflow shows up as a mismatch of the top two bits.
    assign acc_sum = {acc[ACC_WIDTH-1], acc}
                   + {{(ACC_WIDTH-15){grad_data_in[15]}}, grad_data_in};

    always_comb begin
        acc_sat = acc_sum[ACC_WIDTH-1:0];
        if (acc_sum[ACC_WIDTH] != acc_sum[ACC_WIDTH-1])
            acc_sat = acc_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end

    // Both operands are pre-extended to the full product width so the multiply is exact.
    assign acc_ext  = {{16{acc[ACC_WIDTH-1]}}, acc};
    assign lr_ext   = {{ACC_WIDTH{lr_in[15]}}, lr_in};
    assign prod     = acc_ext * lr_ext;
    assign prod_shr = prod >>> 8;

    always_comb begin
        step_sat = prod_shr[15:0];
        if (!((&prod_shr[PW-1:15]) || !(|prod_shr[PW-1:15])))
            step_sat = prod_shr[PW-1] ? 16'h8000 : 16'h7fff;
    end

    assign bias_diff = {bias_out[15], bias_out} - {step[15], step};

    always_comb begin
        bias_sat = bias_diff[15:0];
        if (bias_diff[16] != bias_diff[15])
            bias_sat = bias_diff[16] ? 16'h8000 : 16'h7fff;
    end

    always_comb begin
        state_next = state;
        if (bias_load_in) begin
            state_next = ST_ACCUM;
        end else begin
            case (state)
                ST_ACCUM: if (grad_valid_in && count == LAST_IDX) state_next = ST_SCALE;
                ST_SCALE: state_next = ST_APPLY;
                ST_APPLY: state_next = ST_ACCUM;
                default:  state_next = ST_ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= ST_ACCUM;
            acc                   <= '0;
            count                 <= '0;
            step                  <= '0;
            bias_out              <= '0;
            bias_update_valid_out <= 1'b0;
            drop_sticky_out       <= 1'b0;
        end else begin
            state                 <= state_next;
            bias_update_valid_out <= 1'b0;
            if (bias_load_in) begin
                bias_out        <= bias_init_in;
                acc             <= '0;
                count           <= '0;
                drop_sticky_out <= 1'b0;
            end else begin
                // No backpressure upstream: samples outside ACCUM are lost and flagged.
                if (grad_valid_in && state != ST_ACCUM)
                    drop_sticky_out <= 1'b1;
                case (state)
                    ST_ACCUM: begin
                        if (grad_valid_in) begin
                            acc   <= acc_sat;
                            count <= count + 1'b1;
                        end
                    end
                    ST_SCALE: step <= step_sat;
                    ST_APPLY: begin
                        bias_out              <= bias_sat;
                        bias_update_valid_out <= 1'b1;
                        acc                   <= '0;
                        count                 <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
